// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with terminal-count strobe.
// Runs one-shot (stops in DONE at zero) or auto-reload (periodic tc_pulse
// every N enabled cycles). Per-cycle priority is clear > load > enable.
module countdown_timer #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             tc_pulse
);

  // A MAX_COUNT wider than the count register is clamped to all-ones.
  localparam int MAX_FIT_C = (MAX_COUNT > ((2 ** WIDTH) - 1)) ? ((2 ** WIDTH) - 1) : MAX_COUNT;
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_FIT_C);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = WIDTH'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             busy_r;
  logic             tc_pulse_r;
  logic [WIDTH-1:0] load_sat_s;

  // Saturate the requested start value at MAX_COUNT.
  always_comb begin
    load_sat_s = load_value;
    if (load_value > MAX_C) begin
      load_sat_s = MAX_C;
    end else begin
      load_sat_s = load_value;
    end
  end

  // Counter FSM: state, count, reload value and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      count_r    <= ZERO_C;
      reload_r   <= ZERO_C;
      busy_r     <= 1'b0;
      tc_pulse_r <= 1'b0;
    end else begin
      tc_pulse_r <= 1'b0;
      if (clear) begin
        // Abort: reload_r keeps its value; only count and state are dropped.
        state_r <= ST_IDLE;
        count_r <= ZERO_C;
        busy_r  <= 1'b0;
      end else if (load) begin
        // A load restarts the run even mid-count and never strobes tc_pulse.
        count_r  <= load_sat_s;
        reload_r <= load_sat_s;
        if (load_sat_s != ZERO_C) begin
          state_r <= ST_RUN;
          busy_r  <= 1'b1;
        end else begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      end else begin
        case (state_r)
          ST_RUN: begin
            if (enable) begin
              if (count_r == ONE_C) begin
                // Terminal cycle: auto_reload is only looked at here.
                tc_pulse_r <= 1'b1;
                if (auto_reload) begin
                  count_r <= reload_r;
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
                end else begin
                  count_r <= ZERO_C;
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                end
              end else if (count_r > ONE_C) begin
                count_r <= count_r - ONE_C;
              end else begin
                // count==0 in RUN cannot arise; park safely in IDLE if it does.
                count_r <= ZERO_C;
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              // Paused: hold count and state.
              count_r <= count_r;
            end
          end
          ST_IDLE: begin
            count_r <= count_r;
          end
          ST_DONE: begin
            count_r <= ZERO_C;
          end
          default: begin
            // Illegal encoding: recover to IDLE.
            state_r <= ST_IDLE;
            count_r <= ZERO_C;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count    = count_r;
  assign busy     = busy_r;
  assign tc_pulse = tc_pulse_r;
  assign zero     = (count_r == ZERO_C);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: reset, one-shot, auto-reload, pause,
// priority/restart and saturation (second instance with MAX_COUNT=200).
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       enable;
  logic       auto_reload;

  logic [7:0] count;
  logic       busy;
  logic       zero;
  logic       tc_pulse;

  logic [7:0] s_count;
  logic       s_busy;
  logic       s_zero;
  logic       s_tc_pulse;

  int n_vec;
  int n_err;

  countdown_timer #(.WIDTH(8), .MAX_COUNT(255)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .auto_reload(auto_reload),
    .count(count), .busy(busy), .zero(zero), .tc_pulse(tc_pulse)
  );

  countdown_timer #(.WIDTH(8), .MAX_COUNT(200)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .auto_reload(auto_reload),
    .count(s_count), .busy(s_busy), .zero(s_zero), .tc_pulse(s_tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load value v with a single-cycle load strobe.
  task automatic do_load(input logic [7:0] v);
    load_value = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    // State right after power-on reset release.
    n_vec++;
    if ({count, busy, zero, tc_pulse} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_init: count=%0d busy=%b zero=%b tc=%b, want 0 0 1 0", count, busy, zero, tc_pulse);
    end
    // Reset mid-run at count 5.
    enable = 1'b1;
    auto_reload = 1'b0;
    do_load(8'd8);
    tick(); tick(); tick();
    n_vec++;
    if (count !== 8'd5) begin
      n_err++;
      $display("FAIL reset_pre: count=%0d want 5", count);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({count, busy, zero, tc_pulse} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async: count=%0d busy=%b zero=%b tc=%b, want 0 0 1 0", count, busy, zero, tc_pulse);
    end
    reset = 1'b1;
    enable = 1'b0;
    tick();
    // Enable alone must not start anything after reset.
    enable = 1'b1;
    tick();
    n_vec++;
    if ({count, busy} !== {8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_idle: count=%0d busy=%b want 0 0", count, busy);
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_c;
    enable = 1'b1;
    auto_reload = 1'b0;
    do_load(8'd4);
    n_vec++;
    if ({count, busy, tc_pulse} !== {8'd4, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL oneshot_load: count=%0d busy=%b tc=%b want 4 1 0", count, busy, tc_pulse);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_c = 8'(4 - i);
      n_vec++;
      if ({count, tc_pulse, busy, zero} !== {exp_c, (i == 4), (i != 4), (i == 4)}) begin
        n_err++;
        $display("FAIL oneshot_step%0d: count=%0d tc=%b busy=%b zero=%b want %0d %b %b %b",
                 i, count, tc_pulse, busy, zero, exp_c, (i == 4), (i != 4), (i == 4));
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({count, tc_pulse, busy} !== {8'd0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL oneshot_done%0d: count=%0d tc=%b busy=%b want 0 0 0", i, count, tc_pulse, busy);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [7:0] seq [3];
    seq[0] = 8'd2; seq[1] = 8'd1; seq[2] = 8'd3;
    enable = 1'b1;
    auto_reload = 1'b1;
    do_load(8'd3);
    n_vec++;
    if (count !== 8'd3) begin
      n_err++;
      $display("FAIL auto_load: count=%0d want 3", count);
    end
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        n_vec++;
        if ({count, tc_pulse, busy} !== {seq[j], (j == 2), 1'b1}) begin
          n_err++;
          $display("FAIL auto_p%0d_s%0d: count=%0d tc=%b busy=%b want %0d %b 1",
                   p, j, count, tc_pulse, busy, seq[j], (j == 2));
        end
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    auto_reload = 1'b0;
    n_vec++;
    if ({count, busy, tc_pulse} !== {8'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL auto_clear: count=%0d busy=%b tc=%b want 0 0 0", count, busy, tc_pulse);
    end
  endtask

  task automatic test_pause();
    logic       en_pat [9];
    logic [7:0] exp_c  [9];
    en_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_c  = '{8'd5, 8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    auto_reload = 1'b0;
    enable = 1'b1;
    do_load(8'd6);
    for (int i = 0; i < 9; i++) begin
      enable = en_pat[i];
      tick();
      n_vec++;
      if ({count, tc_pulse, busy} !== {exp_c[i], (i == 8), (i != 8)}) begin
        n_err++;
        $display("FAIL pause_%0d: count=%0d tc=%b busy=%b want %0d %b %b",
                 i, count, tc_pulse, busy, exp_c[i], (i == 8), (i != 8));
      end
    end
  endtask

  task automatic test_priority();
    enable = 1'b1;
    auto_reload = 1'b0;
    do_load(8'd5);
    tick(); tick(); tick();
    n_vec++;
    if (count !== 8'd2) begin
      n_err++;
      $display("FAIL prio_pre: count=%0d want 2", count);
    end
    do_load(8'd9);
    n_vec++;
    if ({count, tc_pulse, busy} !== {8'd9, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL prio_restart: count=%0d tc=%b busy=%b want 9 0 1", count, tc_pulse, busy);
    end
    // Load landing on the terminal cycle wins over the decrement: no pulse.
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if (count !== 8'd1) begin
      n_err++;
      $display("FAIL prio_at1: count=%0d want 1", count);
    end
    do_load(8'd7);
    n_vec++;
    if ({count, tc_pulse, busy} !== {8'd7, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL prio_load_tc: count=%0d tc=%b busy=%b want 7 0 1", count, tc_pulse, busy);
    end
    clear = 1'b1;
    do_load(8'd9);
    clear = 1'b0;
    n_vec++;
    if ({count, busy, zero, tc_pulse} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL prio_clear_load: count=%0d busy=%b zero=%b tc=%b want 0 0 1 0", count, busy, zero, tc_pulse);
    end
    do_load(8'd4);
    do_load(8'd0);
    n_vec++;
    if ({count, busy, zero, tc_pulse} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL prio_load0: count=%0d busy=%b zero=%b tc=%b want 0 0 1 0", count, busy, zero, tc_pulse);
    end
    tick();
    n_vec++;
    if ({count, busy, tc_pulse} !== {8'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL prio_idle_hold: count=%0d busy=%b tc=%b want 0 0 0", count, busy, tc_pulse);
    end
  endtask

  task automatic test_saturation();
    int tc_seen;
    enable = 1'b1;
    auto_reload = 1'b0;
    do_load(8'd199);
    n_vec++;
    if (s_count !== 8'd199) begin
      n_err++;
      $display("FAIL sat_199: count=%0d want 199", s_count);
    end
    do_load(8'd250);
    n_vec++;
    if ({s_count, s_busy, count} !== {8'd200, 1'b1, 8'd250}) begin
      n_err++;
      $display("FAIL sat_250: sat_count=%0d busy=%b full_count=%0d want 200 1 250", s_count, s_busy, count);
    end
    tc_seen = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (s_tc_pulse) tc_seen++;
      if (i == 199 || i == 200) begin
        n_vec++;
        if ({s_count, s_tc_pulse} !== {8'(200 - i), (i == 200)}) begin
          n_err++;
          $display("FAIL sat_edge%0d: count=%0d tc=%b want %0d %b", i, s_count, s_tc_pulse, 200 - i, (i == 200));
        end
      end
    end
    n_vec++;
    if ({tc_seen, s_busy, s_zero} !== {32'd1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL sat_done: pulses=%0d busy=%b zero=%b want 1 0 1", tc_seen, s_busy, s_zero);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    clear = 1'b0;
    load = 1'b0;
    load_value = 8'd0;
    enable = 1'b0;
    auto_reload = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause();
    test_priority();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
